vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//   Source (transmitter) side of vga_if: generates hcount/vcount, sync and blanking for the
//   display pipeline. Drawing stages such as the bird/pipe renderers consume it via vga_if.in.
//   Default mode is 800x600@60 Hz on a 40 MHz pixel clock. Also provides a frame-start strobe
//   and a frame counter, which game logic uses for per-frame physics updates.
// PARAMETERS
//   H_ACTIVE   800   visible pixels per line
//   H_FP       40    horizontal front porch (pixels)
//   H_SYNC     128   hsync pulse width (pixels)
//   H_BP       88    horizontal back porch; H_TOTAL = sum = 1056
//   V_ACTIVE   600   visible lines per frame
//   V_FP       1     vertical front porch (lines)
//   V_SYNC     4     vsync pulse width (lines)
//   V_BP       23    vertical back porch; V_TOTAL = sum = 628
//   SYNC_POL   1'b1  active level of hsync/vsync; the inactive level is ~SYNC_POL
// PORTS
//   clk          in   1   pixel clock; all logic is on posedge
//   rst_n        in   1   asynchronous, active-low reset
//   en           in   1   advance the counters this cycle; when low, hold all state
//   vout         out  if  vga_if.out: hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk
//   frame_start  out  1   one-cycle pulse coincident with the output pair (0,0) after a wrap
//   frame_cnt    out  16  completed-frame counter, wraps 16'hFFFF -> 0
// BEHAVIOUR
//   - Reset (async assert, sync release): hcount=0, vcount=0, hblnk=0, vblnk=0,
//     hsync=vsync=~SYNC_POL, frame_start=0, frame_cnt=0. Reset mid-line aborts immediately;
//     the first cycle after release shows (0,0) with no frame_start.
//   - All outputs are registered and mutually aligned: every flag describes the hcount/vcount
//     values driven in the same cycle. Flags are computed from next-state counts (no skew).
//   - Horizontal: with en=1, hcount increments each clk; at H_TOTAL-1 it wraps to 0.
//   - Vertical: vcount increments only on the cycle hcount wraps; at V_TOTAL-1 (with the
//     hcount wrap) it wraps to 0.
//   - Per-axis FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
//     H: ACTIVE [0,799], FRONT [800,839], SYNC [840,967], BACK [968,1055].
//     V: ACTIVE [0,599], FRONT [600], SYNC [601,604], BACK [605,627].
//     hblnk = (H state != ACTIVE); vblnk = (V state != ACTIVE).
//     hsync = SYNC_POL iff H state == SYNC; vsync is defined likewise on V state.
//   - A zero-length porch parameter skips that state (transition taken in the same cycle).
//   - frame_start=1 for exactly one cycle when the outputs go from (H_TOTAL-1, V_TOTAL-1) to
//     (0,0). frame_cnt increments on that same edge and is visible in that same cycle.
//   - en=0: counts, states, flags and frame_cnt hold; frame_start is forced to 0.
//     If en drops on the wrap cycle, the pulse is not repeated when en returns.
//   - Widths: counters are 11 bits. An elaboration check requires H_TOTAL and V_TOTAL <= 2048.
// STRUCTURE
//   - vga_pkg: typedef enum {ACTIVE, FRONT, SYNC, BACK} vga_phase_t; default timing
//     localparams; typedef logic [10:0] vga_cnt_t.
//   - Sub-module vga_axis_cnt (ACTIVE/FP/SYNC/BP params; inputs step; outputs cnt, phase,
//     wrap) is instantiated twice. The H instance uses step=en; the V instance uses
//     step=en & h_wrap. The top level registers the flags and frame logic.
// TESTING
//   1. Reset: hold rst_n=0, then release with en=1 -> cycle 0 shows (0,0), hblnk=0,
//      hsync=0, frame_start=0, frame_cnt=0.
//   2. Line timing: count cycles from release -> hblnk rises at hcount=800; hsync is high for
//      hcount 840..967 (128 cycles); hcount 1055 -> 0 while vcount 0 -> 1.
//   3. Frame timing: vblnk is high for vcount 600..627; vsync is high for lines 601..604.
//      frame_start first pulses 663168 cycles (1056*628) after release, then frame_cnt=1.
//   4. Enable: drop en at hcount=500 for 10 cycles -> outputs frozen at 500 with no
//      frame_start; resumes at 501. Also drop en on the wrap cycle -> exactly one pulse.
//   5. Async reset mid-frame: pull rst_n low at (700,300) between clock edges -> outputs hit
//      reset values before the next edge; frame_cnt returns to 0.
//   6. Small mode (H 8/1/2/1, V 4/0/1/1, SYNC_POL=0): check active-low syncs, the skipped
//      V front porch, and frame_cnt wrapping from FFFF to 0.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared types, default 800x600@60 timing and the phase decode
//               used by the VGA timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } vga_phase_t;

    typedef logic [10:0] vga_cnt_t;

    localparam int c_H_ACTIVE  = 800;
    localparam int c_H_FP      = 40;
    localparam int c_H_SYNC    = 128;
    localparam int c_H_BP      = 88;
    localparam int c_V_ACTIVE  = 600;
    localparam int c_V_FP      = 1;
    localparam int c_V_SYNC    = 4;
    localparam int c_V_BP      = 23;
    localparam int c_CNT_RANGE = 2048;

    // Region lookup by position; a zero-length region is simply never selected.
    function automatic vga_phase_t phase_of(input vga_cnt_t cnt, input int active_len,
                                            input int fp_len, input int sync_len);
        int c;
        c = int'(cnt);
        if (c < active_len)
            return ACTIVE;
        else if (c < active_len + fp_len)
            return FRONT;
        else if (c < active_len + fp_len + sync_len)
            return SYNC;
        else
            return BACK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_axis_cnt.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_cnt
// Description : One timing axis: wrapping position counter plus its
//               ACTIVE/FRONT/SYNC/BACK phase register.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int ACTIVE_LEN = c_H_ACTIVE,
    parameter int FP_LEN     = c_H_FP,
    parameter int SYNC_LEN   = c_H_SYNC,
    parameter int BP_LEN     = c_H_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    output vga_cnt_t   cnt,
    output vga_phase_t phase_nxt,
    output logic       wrap
);

    localparam int       TOTAL  = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;
    localparam vga_cnt_t c_LAST = vga_cnt_t'(TOTAL - 1);

    if (TOTAL > c_CNT_RANGE) begin : g_total_check
        $error("vga_axis_cnt: axis total %0d exceeds the 11-bit counter range", TOTAL);
    end

    vga_cnt_t   r_cnt;
    vga_phase_t r_phase;
    vga_cnt_t   w_cnt_nxt;
    logic       w_last;

    assign w_last = (r_cnt == c_LAST);
    assign wrap   = step & w_last;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (step)
            w_cnt_nxt = w_last ? '0 : r_cnt + 11'd1;
    end

    // Next phase follows the next position so the phase never lags the count.
    assign phase_nxt = step ? phase_of(w_cnt_nxt, ACTIVE_LEN, FP_LEN, SYNC_LEN) : r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= phase_of('0, ACTIVE_LEN, FP_LEN, SYNC_LEN);
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_phase <= phase_nxt;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing source: counters, sync, blanking, frame
//               start strobe and completed-frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = c_H_ACTIVE,
    parameter int   H_FP     = c_H_FP,
    parameter int   H_SYNC   = c_H_SYNC,
    parameter int   H_BP     = c_H_BP,
    parameter int   V_ACTIVE = c_V_ACTIVE,
    parameter int   V_FP     = c_V_FP,
    parameter int   V_SYNC   = c_V_SYNC,
    parameter int   V_BP     = c_V_BP,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    vga_phase_t  w_h_phase_nxt;
    vga_phase_t  w_v_phase_nxt;
    logic        w_h_wrap;
    logic        w_v_wrap;

    logic        r_hsync;
    logic        r_vsync;
    logic        r_hblnk;
    logic        r_vblnk;
    logic        r_frame_start;
    logic [15:0] r_frame_cnt;

    vga_axis_cnt #(
        .ACTIVE_LEN (H_ACTIVE),
        .FP_LEN     (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BP_LEN     (H_BP)
    ) u_h_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (en),
        .cnt       (hcount),
        .phase_nxt (w_h_phase_nxt),
        .wrap      (w_h_wrap)
    );

    vga_axis_cnt #(
        .ACTIVE_LEN (V_ACTIVE),
        .FP_LEN     (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BP_LEN     (V_BP)
    ) u_v_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (en & w_h_wrap),
        .cnt       (vcount),
        .phase_nxt (w_v_phase_nxt),
        .wrap      (w_v_wrap)
    );

    // A vertical wrap only happens on a horizontal wrap, so it marks the frame edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= 16'd0;
        end else begin
            r_hsync       <= (w_h_phase_nxt == SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (w_v_phase_nxt == SYNC) ? SYNC_POL : ~SYNC_POL;
            r_hblnk       <= (w_h_phase_nxt != ACTIVE);
            r_vblnk       <= (w_v_phase_nxt != ACTIVE);
            r_frame_start <= w_v_wrap;
            if (w_v_wrap)
                r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblnk       = r_hblnk;
    assign vblnk       = r_vblnk;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire
